// File: rtl/router_pkt_src.sv
// Router packet source: buffers a payload, then sends header, payload and parity.
// Optional PARITY_CORRUPT_EN adds a corrupt input that flips parity bit 0.
module router_pkt_src #(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_DEST   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
`ifdef PARITY_CORRUPT_EN
    input  logic       corrupt,
`endif
    output logic       req_ready,
    output logic       req_err,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    localparam logic [1:0] MAX_D    = MAX_DEST[1:0];
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  dest_q;
    logic [5:0]  len_q;
    logic [5:0]  cnt_q;
    logic [7:0]  par_q;
    logic [3:0]  gcnt_q;
    logic [7:0]  buffer [0:62];
    logic [7:0]  hdr;
    logic [7:0]  par_out;
    logic        cnt_last;
    logic        req_ok;
    logic        accept;
    logic        reject;
    logic        load_we;
`ifdef PARITY_CORRUPT_EN
    logic        corrupt_q;
`endif

    assign hdr      = {len_q, dest_q};
    assign cnt_last = (cnt_q == len_q - 6'd1);
    assign req_ok   = (len != 6'd0) && (dest <= MAX_D);

`ifdef PARITY_CORRUPT_EN
    assign par_out = par_q ^ {7'd0, corrupt_q};
`else
    assign par_out = par_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        pl_ready  = 1'b0;
        pkt_valid = 1'b0;
        data_out  = 8'd0;
        accept    = 1'b0;
        reject    = 1'b0;
        load_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (start) begin
                    if (req_ok) begin
                        accept  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                pl_ready = 1'b1;
                if (pl_valid) begin
                    load_we = 1'b1;
                    if (cnt_last) state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                pkt_valid = 1'b1;
                data_out  = hdr;
                if (!busy) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                pkt_valid = 1'b1;
                data_out  = buffer[cnt_q];
                if (!busy && cnt_last) state_d = S_PARITY;
            end
            S_PARITY: begin
                data_out = par_out;
                if (!busy) state_d = S_GAP;
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q    <= 2'd0;
            len_q     <= 6'd0;
            cnt_q     <= 6'd0;
            par_q     <= 8'd0;
            gcnt_q    <= 4'd0;
            req_err   <= 1'b0;
            done      <= 1'b0;
`ifdef PARITY_CORRUPT_EN
            corrupt_q <= 1'b0;
`endif
        end else begin
            req_err <= reject;
            done    <= (state_q == S_PARITY) && !busy;
            if (accept) begin
                dest_q    <= dest;
                len_q     <= len;
                cnt_q     <= 6'd0;
                par_q     <= 8'd0;
`ifdef PARITY_CORRUPT_EN
                corrupt_q <= corrupt;
`endif
            end
            // Header folds into parity with the last load; cnt rewinds for payload.
            if (load_we) begin
                par_q <= par_q ^ pl_data ^ (cnt_last ? hdr : 8'd0);
                cnt_q <= cnt_last ? 6'd0 : cnt_q + 6'd1;
            end
            if (state_q == S_PAYLOAD && !busy && !cnt_last) begin
                cnt_q <= cnt_q + 6'd1;
            end
            if (state_q == S_PARITY) begin
                gcnt_q <= 4'd0;
            end else if (state_q == S_GAP) begin
                gcnt_q <= gcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_we) buffer[cnt_q] <= pl_data;
    end

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: basic, stall, reject, max length, reset abort.
// Define PARITY_CORRUPT_EN to also cover the parity corruption input.
module tb_router_pkt_src;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic       corrupt;
    logic       req_ready;
    logic       req_err;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;

    int checks = 0;
    int passed = 0;
    logic [7:0] pl_buf [0:62];

    always #5 clk = ~clk;

    router_pkt_src #(.GAP_CYCLES(2), .MAX_DEST(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dest(dest),
        .len(len),
`ifdef PARITY_CORRUPT_EN
        .corrupt(corrupt),
`endif
        .req_ready(req_ready),
        .req_err(req_err),
        .pl_data(pl_data),
        .pl_valid(pl_valid),
        .pl_ready(pl_ready),
        .busy(busy),
        .pkt_valid(pkt_valid),
        .data_out(data_out),
        .done(done)
    );

    task automatic request(input logic [1:0] d, input logic [5:0] l,
                           input logic c);
        @(negedge clk);
        start = 1'b1;
        dest = d;
        len = l;
        corrupt = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_payload(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            pl_valid = 1'b1;
            pl_data = pl_buf[i];
            @(negedge clk);
            if (gaps && i < n - 1) begin
                pl_valid = 1'b0;
                pl_data = 8'hEE;
                @(negedge clk);
            end
        end
        pl_valid = 1'b0;
        pl_data = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL %s_idle: req_ready=%b required 1", name, req_ready);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        dest = 2'd0;
        len = 6'd0;
        corrupt = 1'b0;
        pl_data = 8'd0;
        pl_valid = 1'b0;
        busy = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, req_err, pl_ready, pkt_valid, done} !== 5'b10000)
            $display("FAIL reset_flags: got %b required 10000",
                     {req_ready, req_err, pl_ready, pkt_valid, done});
        else passed++;
        checks++;
        if (data_out !== 8'h00)
            $display("FAIL reset_data: got %h required 00", data_out);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] exp_d [0:4];
        logic       exp_v [0:4];
        exp_d = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pl_buf[0] = 8'hA1;
        pl_buf[1] = 8'hB2;
        pl_buf[2] = 8'hC3;
        request(2'd1, 6'd3, 1'b0);
        checks++;
        if (pl_ready !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL basic_load: pl_ready=%b req_ready=%b required 1 0",
                     pl_ready, req_ready);
        else passed++;
        load_payload(3, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (data_out !== exp_d[i] || pkt_valid !== exp_v[i] ||
                done !== 1'b0)
                $display("FAIL basic_byte%0d: got %h/%b/%b required %h/%b/0",
                         i, data_out, pkt_valid, done, exp_d[i], exp_v[i]);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b0)
            $display("FAIL basic_done: done=%b req_ready=%b required 1 0",
                     done, req_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL basic_gap: done=%b req_ready=%b required 0 0",
                     done, req_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL basic_ready: req_ready=%b required 1", req_ready);
        else passed++;
    endtask

    task automatic test_busy_stall;
        int stall_ok;
        pl_buf[0] = 8'hA1;
        pl_buf[1] = 8'hB2;
        pl_buf[2] = 8'hC3;
        request(2'd1, 6'd3, 1'b0);
        load_payload(3, 0);
        checks++;
        if (data_out !== 8'h0D || pkt_valid !== 1'b1)
            $display("FAIL stall_hdr: got %h/%b required 0d/1",
                     data_out, pkt_valid);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        busy = 1'b1;
        start = 1'b1;
        dest = 2'd3;
        len = 6'd0;
        stall_ok = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_out === 8'hB2 && pkt_valid === 1'b1 && req_err === 1'b0)
                stall_ok++;
            if (i < 3) @(negedge clk);
        end
        busy = 1'b0;
        start = 1'b0;
        checks++;
        if (stall_ok !== 4)
            $display("FAIL stall_hold: B2 held %0d cycles required 4",
                     stall_ok);
        else passed++;
        @(negedge clk);
        checks++;
        if (data_out !== 8'hC3 || pkt_valid !== 1'b1)
            $display("FAIL stall_next: got %h/%b required c3/1",
                     data_out, pkt_valid);
        else passed++;
        @(negedge clk);
        busy = 1'b1;
        @(negedge clk);
        checks++;
        if (data_out !== 8'hDD || pkt_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL stall_par: got %h/%b/%b required dd/0/0",
                     data_out, pkt_valid, done);
        else passed++;
        busy = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1)
            $display("FAIL stall_done: done=%b required 1", done);
        else passed++;
        wait_idle("stall");
    endtask

    task automatic test_reject;
        logic [1:0] d [0:1];
        logic [5:0] l [0:1];
        d = '{2'd3, 2'd0};
        l = '{6'd5, 6'd0};
        for (int i = 0; i < 2; i++) begin
            request(d[i], l[i], 1'b0);
            checks++;
            if (req_err !== 1'b1 || req_ready !== 1'b1 || pl_ready !== 1'b0)
                $display("FAIL reject%0d_err: err=%b rdy=%b plr=%b required 1 1 0",
                         i, req_err, req_ready, pl_ready);
            else passed++;
            @(negedge clk);
            checks++;
            if (req_err !== 1'b0 || req_ready !== 1'b1 || pl_ready !== 1'b0)
                $display("FAIL reject%0d_after: err=%b rdy=%b plr=%b required 0 1 0",
                         i, req_err, req_ready, pl_ready);
            else passed++;
        end
    endtask

    task automatic test_max_len;
        logic [7:0] exp_par;
        int bad;
        exp_par = 8'hFE;
        for (int i = 0; i < 63; i++) begin
            pl_buf[i] = 8'(i);
            exp_par = exp_par ^ 8'(i);
        end
        request(2'd2, 6'd63, 1'b0);
        load_payload(63, 1);
        checks++;
        if (data_out !== 8'hFE || pkt_valid !== 1'b1)
            $display("FAIL max_hdr: got %h/%b required fe/1",
                     data_out, pkt_valid);
        else passed++;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            checks++;
            if (data_out !== 8'(i) || pkt_valid !== 1'b1) begin
                if (bad < 4)
                    $display("FAIL max_byte%0d: got %h/%b required %h/1",
                             i, data_out, pkt_valid, 8'(i));
                bad++;
            end else passed++;
            @(negedge clk);
        end
        checks++;
        if (data_out !== exp_par || pkt_valid !== 1'b0)
            $display("FAIL max_par: got %h/%b required %h/0",
                     data_out, pkt_valid, exp_par);
        else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b1)
            $display("FAIL max_done: done=%b required 1", done);
        else passed++;
        wait_idle("max");
    endtask

    task automatic test_reset_abort;
        logic [7:0] exp_d [0:3];
        logic       exp_v [0:3];
        pl_buf[0] = 8'h11;
        pl_buf[1] = 8'h22;
        pl_buf[2] = 8'h33;
        pl_buf[3] = 8'h44;
        request(2'd0, 6'd4, 1'b0);
        load_payload(4, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 8'h33)
            $display("FAIL abort_pre: got %h required 33", data_out);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || req_ready !== 1'b1 ||
            done !== 1'b0 || pl_ready !== 1'b0)
            $display("FAIL abort_state: pv=%b d=%h rdy=%b done=%b required 0 00 1 0",
                     pkt_valid, data_out, req_ready, done);
        else passed++;
        exp_d = '{8'h0A, 8'h5A, 8'hA5, 8'hF5};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        pl_buf[0] = 8'h5A;
        pl_buf[1] = 8'hA5;
        request(2'd2, 6'd2, 1'b0);
        load_payload(2, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== exp_d[i] || pkt_valid !== exp_v[i])
                $display("FAIL fresh_byte%0d: got %h/%b required %h/%b",
                         i, data_out, pkt_valid, exp_d[i], exp_v[i]);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1)
            $display("FAIL fresh_done: done=%b required 1", done);
        else passed++;
        wait_idle("fresh");
    endtask

`ifdef PARITY_CORRUPT_EN
    task automatic test_corrupt;
        pl_buf[0] = 8'hA1;
        pl_buf[1] = 8'hB2;
        pl_buf[2] = 8'hC3;
        request(2'd1, 6'd3, 1'b1);
        corrupt = 1'b0;
        load_payload(3, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (data_out !== 8'hDC || pkt_valid !== 1'b0)
            $display("FAIL corrupt_par: got %h/%b required dc/0",
                     data_out, pkt_valid);
        else passed++;
        wait_idle("corrupt");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_reject();
        test_max_len();
        test_reset_abort();
`ifdef PARITY_CORRUPT_EN
        test_corrupt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Packet source that drives the router input port: the transmit end of the router's header/payload/parity byte protocol.
- Accepts a transfer request (destination, length) and fetches the payload into an internal buffer while accumulating parity.
- Then emits header, payload and parity bytes on the pkt_valid/data bus, stalling on router busy.
- Used as the on-chip traffic generator ahead of the router and as the bench driver.

Parameters:
- GAP_CYCLES, 2, idle cycles forced between parity-byte acceptance and the next request (1..15).
- MAX_DEST, 2, highest legal destination address; any dest > MAX_DEST is rejected.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  request strobe, sampled only when req_ready=1
- dest  in  2  destination address for the request
- len  in  6  payload length in bytes, legal range 1..63
- req_ready  out  1  high in IDLE only
- req_err  out  1  one-cycle pulse: request rejected
- pl_data  in  8  payload byte from upstream
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  high in LOAD only
- busy  in  1  router busy; the byte on data_out is consumed on an edge where busy=0
- pkt_valid  out  1  high while header/payload presented
- data_out  out  8  byte to router
- done  out  1  one-cycle pulse when parity byte is consumed

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, except req_ready=1. State=IDLE, counters and parity = 0. Reset mid-packet aborts immediately; no parity byte is sent.
- States and transitions:
  - IDLE: req_ready=1. start=1 with len!=0 and dest<=MAX_DEST latches dest/len, clears parity and byte count, and moves to LOAD. Otherwise start raises req_err for the next cycle and the block stays in IDLE.
  - LOAD: pl_ready=1. Each edge with pl_valid=1 writes pl_data to buffer[cnt], XORs it into parity and increments cnt. When the len-th byte is accepted, go to HEADER. No timeout; pl_valid low simply waits.
  - HEADER: pkt_valid=1, data_out={len,dest}; the header is also XORed into parity. Advance to PAYLOAD (cnt=0) on an edge with busy=0.
  - PAYLOAD: pkt_valid=1, data_out=buffer[cnt]. On busy=0, cnt increments. After byte len-1 is consumed, go to PARITY.
  - PARITY: pkt_valid=0, data_out=parity (header XOR all payload). On busy=0, pulse done for one cycle and go to GAP.
  - GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
- Stall rule: while busy=1, data_out and pkt_valid hold stable with no exceptions. busy is ignored in IDLE, LOAD and GAP.
- Timing: header appears the cycle after the last LOAD acceptance. Minimum packet = len+2 output cycles.
- Buffer: 63x8. It is never read beyond len-1, and stale contents are never emitted.
- start while req_ready=0 is ignored, with no req_err.

Optional Feature:
- Macro PARITY_CORRUPT_EN.
- When defined: adds input corrupt (1 bit), sampled with an accepted start. If set, the emitted parity byte has bit 0 inverted, used to exercise the router's err path.
- When undefined: the port is absent and parity is always correct.

Test Plan:
- Basic packet: dest=1, len=3, payload A1,B2,C3, busy=0 -> pl_ready for 3 accepts. Then data_out 0x0D (pkt_valid=1), A1, B2, C3, then 0xDD with pkt_valid=0. done pulses once, and req_ready returns after 2 GAP cycles.
- Busy stall: same packet, busy=1 for 3 cycles while B2 is presented -> data_out holds B2 and pkt_valid=1 for 4 cycles. Parity stays 0xDD.
- Rejection: dest=3, len=5 -> req_err for 1 cycle, pl_ready never asserts, req_ready stays 1. Same for dest=0, len=0.
- Max length with source gaps: len=63, payload 0..62, pl_valid toggling every other cycle -> all 63 bytes buffered. Header 0xFC|dest, payload emitted in order, parity correct.
- Reset mid-payload: reset asserted after 2 payload bytes are consumed -> next cycle pkt_valid=0, data_out=0, req_ready=1, no done. A fresh packet then runs correctly.
- Corruption (PARITY_CORRUPT_EN defined): basic packet with corrupt=1 -> parity byte 0xDC.
